// File: rtl/alu_display_scheduler.sv
// alu_display_scheduler: four-digit seven-segment scan showing A, B, A+B and A-B, with operands latched once per frame
//   clk        : system clock; all state changes on the rising edge
//   btnC       : asynchronous active-low reset
//   a, b       : 4-bit operands from the switch sampler
//   in_valid   : a/b are valid for capture
//   in_ready   : a/b are accepted this cycle (in IDLE, or at the end of a frame)
//   an         : active-low one-hot anode enables; an[0] is the rightmost digit
//   digit      : hex value sent to the seg encoder
//   digit_sel  : index of the lit digit (0=R, 1=RC, 2=LC, 3=L)
//   frame_done : one-cycle pulse at the end of a frame
//   Define ALU_DISP_BLANK_GAP_EN to insert one blank cycle after each digit (anti-ghosting).
module alu_display_scheduler #(
    parameter int DIVIDE_BY = 1000
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] an,
    output logic [3:0] digit,
    output logic [1:0] digit_sel,
    output logic       frame_done
);
`ifdef ALU_DISP_BLANK_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif
    typedef enum logic {IDLE, SCAN} state_t;
    state_t      r_state, w_state_nxt;
    logic [15:0] r_count, w_count_nxt;
    logic [1:0]  r_sel, w_sel_nxt;
    logic [3:0]  r_a, r_b, w_a_nxt, w_b_nxt;
    logic        r_blank, w_blank_nxt;
    logic        w_tick, w_end, w_accept;
    logic [3:0]  w_sum, w_diff;
    assign w_tick   = r_count == 16'(DIVIDE_BY - 1);
    // Frame ends on the sel-3 tick, or on the blank cycle that follows it when the gap is enabled.
    assign w_end    = (r_state == SCAN) && (r_sel == 2'd3) && (GAP ? r_blank : w_tick);
    assign w_accept = in_valid && in_ready;
    assign w_sum    = r_a + r_b;
    assign w_diff   = r_a - r_b;
    assign in_ready   = (r_state == IDLE) || w_end;
    assign frame_done = w_end;
    assign digit_sel  = r_sel;
    // Decode uses only registered operands and select, so a/b never reach digit combinationally.
    assign an    = (r_state == IDLE || r_blank) ? 4'b1111 : ~(4'b0001 << r_sel);
    assign digit = r_sel == 2'd0 ? r_a : r_sel == 2'd1 ? r_b : r_sel == 2'd2 ? w_sum : w_diff;
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_sel_nxt   = r_sel;
        w_blank_nxt = r_blank;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        if (w_accept) begin
            w_state_nxt = SCAN;
            w_count_nxt = '0;
            w_sel_nxt   = 2'd0;
            w_blank_nxt = 1'b0;
            w_a_nxt     = a;
            w_b_nxt     = b;
        end else if (r_state == SCAN) begin
            if (r_blank) begin
                // Digit stays selected through its blank cycle; advance afterwards.
                w_blank_nxt = 1'b0;
                w_sel_nxt   = r_sel + 2'd1;
            end else if (w_tick) begin
                w_count_nxt = '0;
                w_blank_nxt = GAP;
                w_sel_nxt   = GAP ? r_sel : r_sel + 2'd1;
            end else begin
                w_count_nxt = r_count + 16'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge btnC) begin
        if (!btnC) begin
            r_state <= IDLE;
            r_count <= '0;
            r_sel   <= 2'd0;
            r_blank <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_sel   <= w_sel_nxt;
            r_blank <= w_blank_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
        end
    end
endmodule

// File: tb/tb_alu_display_scheduler.sv
// tb_alu_display_scheduler: self-checking bench for alu_display_scheduler (DIVIDE_BY=1 and DIVIDE_BY=3 instances)
module tb_alu_display_scheduler;
`ifdef ALU_DISP_BLANK_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif
    logic       clk = 1'b0;
    logic       btnC;
    logic [3:0] a, b;
    logic       in_valid;
    logic       rdy1, fd1, rdy3, fd3;
    logic [3:0] an1, dig1, an3, dig3;
    logic [1:0] sel1, sel3;
    always #5 clk = ~clk;
    alu_display_scheduler #(.DIVIDE_BY(1)) u1 (
        .clk(clk), .btnC(btnC), .a(a), .b(b), .in_valid(in_valid), .in_ready(rdy1),
        .an(an1), .digit(dig1), .digit_sel(sel1), .frame_done(fd1));
    alu_display_scheduler #(.DIVIDE_BY(3)) u3 (
        .clk(clk), .btnC(btnC), .a(a), .b(b), .in_valid(in_valid), .in_ready(rdy3),
        .an(an3), .digit(dig3), .digit_sel(sel3), .frame_done(fd3));
    int checks = 0;
    int errors = 0;
    int dv[2] = '{1, 3};
    int m_scan[2], m_pos[2], m_a[2], m_b[2];
    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, act, exp);
        end
    endtask
    // Reference: a frame is a run of cycles since acceptance; digit index = position / digit period.
    task automatic predict(input int k, output int e_an, output int e_dig, output int e_sel,
                           output int e_rdy, output int e_fd);
        int per, s;
        int v[4];
        per = dv[k] + GAP;
        if (m_scan[k] == 0) begin
            e_an = 15; e_dig = 0; e_sel = 0; e_rdy = 1; e_fd = 0;
        end else begin
            s = m_pos[k] / per;
            v[0] = m_a[k];
            v[1] = m_b[k];
            v[2] = (m_a[k] + m_b[k]) % 16;
            v[3] = (m_a[k] - m_b[k] + 16) % 16;
            e_an  = (GAP == 1 && m_pos[k] % per == dv[k]) ? 15 : 15 - (1 << s);
            e_dig = v[s];
            e_sel = s;
            e_fd  = (m_pos[k] == 4 * per - 1) ? 1 : 0;
            e_rdy = e_fd;
        end
    endtask
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_scan[k] = 0; m_pos[k] = 0; m_a[k] = 0; m_b[k] = 0;
        end
    endtask
    task automatic check_model();
        int e_an, e_dig, e_sel, e_rdy, e_fd;
        for (int k = 0; k < 2; k++) begin
            predict(k, e_an, e_dig, e_sel, e_rdy, e_fd);
            chk($sformatf("u%0d.an", dv[k]), int'(k == 1 ? an3 : an1), e_an);
            chk($sformatf("u%0d.digit", dv[k]), int'(k == 1 ? dig3 : dig1), e_dig);
            chk($sformatf("u%0d.digit_sel", dv[k]), int'(k == 1 ? sel3 : sel1), e_sel);
            chk($sformatf("u%0d.in_ready", dv[k]), int'(k == 1 ? rdy3 : rdy1), e_rdy);
            chk($sformatf("u%0d.frame_done", dv[k]), int'(k == 1 ? fd3 : fd1), e_fd);
        end
    endtask
    task automatic model_step();
        int e_an, e_dig, e_sel, e_rdy, e_fd;
        for (int k = 0; k < 2; k++) begin
            predict(k, e_an, e_dig, e_sel, e_rdy, e_fd);
            if (!btnC) begin
                m_scan[k] = 0; m_pos[k] = 0; m_a[k] = 0; m_b[k] = 0;
            end else if (e_rdy == 1 && in_valid) begin
                m_scan[k] = 1; m_pos[k] = 0; m_a[k] = int'(a); m_b[k] = int'(b);
            end else if (m_scan[k] == 1) begin
                m_pos[k] = (m_pos[k] + 1) % (4 * (dv[k] + GAP));
            end
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        btnC = 1'b0;
        model_reset();
        cyc();
        btnC = 1'b1;
    endtask
    typedef struct {
        logic [3:0] a, b;
        logic       v;
        logic [3:0] an, dig;
        logic       fd;
    } vec_t;
    vec_t tv[8];
    int   ntv;
    int   exp3[24] = '{2,2,2,1,1,1,3,3,3,1,1,1,9,9,9,1,1,1,10,10,10,8,8,8};
    int   an_of[4] = '{14, 13, 11, 7};
    initial begin
`ifdef ALU_DISP_BLANK_GAP_EN
        tv[0] = '{4'd4, 4'd4, 1'b1, 4'b1110, 4'd4, 1'b0};
        tv[1] = '{4'd4, 4'd4, 1'b0, 4'b1111, 4'd4, 1'b0};
        tv[2] = '{4'd4, 4'd4, 1'b0, 4'b1101, 4'd4, 1'b0};
        tv[3] = '{4'd4, 4'd4, 1'b0, 4'b1111, 4'd4, 1'b0};
        tv[4] = '{4'd4, 4'd4, 1'b0, 4'b1011, 4'd8, 1'b0};
        tv[5] = '{4'd4, 4'd4, 1'b0, 4'b1111, 4'd8, 1'b0};
        tv[6] = '{4'd4, 4'd4, 1'b0, 4'b0111, 4'd0, 1'b0};
        tv[7] = '{4'd4, 4'd4, 1'b0, 4'b1111, 4'd0, 1'b1};
        ntv = 8;
`else
        tv[0] = '{4'd3, 4'd5, 1'b1, 4'b1110, 4'd3, 1'b0};
        tv[1] = '{4'd3, 4'd5, 1'b0, 4'b1101, 4'd5, 1'b0};
        tv[2] = '{4'd3, 4'd5, 1'b0, 4'b1011, 4'd8, 1'b0};
        tv[3] = '{4'd3, 4'd5, 1'b0, 4'b0111, 4'd14, 1'b1};
        tv[4] = '{4'd3, 4'd5, 1'b0, 4'b1110, 4'd3, 1'b0};
        ntv = 5;
`endif
        btnC = 1'b1; a = '0; b = '0; in_valid = 1'b0;
        #1 btnC = 1'b0;
        model_reset();
        repeat (3) cyc();
        btnC = 1'b1;
        repeat (10) begin
            cyc();
            chk("idle.an", int'(an1), 15);
            chk("idle.frame_done", int'(fd3), 0);
        end
        for (int i = 0; i < ntv; i++) begin
            a = tv[i].a; b = tv[i].b; in_valid = tv[i].v;
            cyc();
            chk($sformatf("tbl[%0d].an", i), int'(an1), int'(tv[i].an));
            chk($sformatf("tbl[%0d].digit", i), int'(dig1), int'(tv[i].dig));
            chk($sformatf("tbl[%0d].frame_done", i), int'(fd1), int'(tv[i].fd));
        end
`ifndef ALU_DISP_BLANK_GAP_EN
        do_reset();
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4); b = 4'(i); in_valid = 1'b1;
            cyc();
            for (int j = 0; j < 3; j++) begin
                a = 4'($urandom); b = 4'($urandom); in_valid = 1'($urandom % 2);
                cyc();
            end
        end
        do_reset();
        a = 4'd15; b = 4'd15; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        chk("edge15.sum", int'(dig1), 14);
        cyc();
        chk("edge15.diff", int'(dig1), 0);
        a = 4'd0; b = 4'd1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("edge01.diff", int'(dig1), 15);
        do_reset();
        a = 4'd2; b = 4'd1; in_valid = 1'b1;
        cyc();
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("div3[%0d].digit", c), int'(dig3), exp3[c]);
            chk($sformatf("div3[%0d].an", c), int'(an3), an_of[(c / 3) % 4]);
            chk($sformatf("div3[%0d].frame_done", c), int'(fd3), (c == 11 || c == 23) ? 1 : 0);
            a = (c >= 3) ? 4'd9 : 4'd2;
            cyc();
        end
`endif
        do_reset();
        repeat (600) begin
            a = 4'($urandom); b = 4'($urandom); in_valid = 1'(($urandom % 3) != 0);
            if ($urandom % 150 == 0) do_reset();
            else cyc();
        end
        do_reset();
        a = 4'd7; b = 4'd3; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        begin
            int n = 0;
            while (sel3 != 2'd2 && n < 50) begin
                cyc();
                n++;
            end
            chk("reach_sel2", (n < 50) ? 1 : 0, 1);
        end
        #2 btnC = 1'b0;
        #1;
        model_reset();
        chk("async.an1", int'(an1), 15);
        chk("async.an3", int'(an3), 15);
        chk("async.digit3", int'(dig3), 0);
        chk("async.sel3", int'(sel3), 0);
        chk("async.in_ready3", int'(rdy3), 1);
        chk("async.frame_done3", int'(fd3), 0);
        cyc();
        btnC = 1'b1;
        repeat (10) cyc();
        chk("post_reset.an3", int'(an3), 15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
